// File: rtl/exc_pkg.sv
// Shared types and constants for the exception sequencer: state encoding,
// exception codes, vector base/offset constants and the selected-event payload.
package exc_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CODE_W = 5;

  // Bit positions inside CP0 STATUS / CAUSE
  localparam int unsigned ST_IE  = 0;
  localparam int unsigned ST_EXL = 1;
  localparam int unsigned ST_ERL = 2;
  localparam int unsigned ST_BEV = 22;
  localparam int unsigned CA_IV  = 23;

  localparam logic [CODE_W-1:0] EXC_INT = 5'h00;
  localparam logic [CODE_W-1:0] EXC_SYS = 5'h08;
  localparam logic [CODE_W-1:0] EXC_RI  = 5'h0A;
  localparam logic [CODE_W-1:0] EXC_OV  = 5'h0C;

  localparam logic [DATA_W-1:0] BASE_NORMAL = 32'h8000_0000;
  localparam logic [DATA_W-1:0] BASE_BEV    = 32'hBFC0_0200;
  localparam logic [DATA_W-1:0] OFF_GEN     = 32'h0000_0180;
  localparam logic [DATA_W-1:0] OFF_VEC     = 32'h0000_0200;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_REDIRECT = 2'd2
  } state_t;

  typedef struct packed {
    logic              valid;
    logic              is_eret;
    logic              is_int;
    logic [CODE_W-1:0] code;
  } evt_t;

endpackage

// File: rtl/exc_seq_if.sv
// Bundle of event inputs, CP0 state and sequencer outputs for exc_seq.
interface exc_seq_if;
  import exc_pkg::*;

  logic              stall;
  logic              id_syscall;
  logic              id_unknown;
  logic              exe_overflow;
  logic              id_eret;
  logic              int_req;
  logic [DATA_W-1:0] status;
  logic [DATA_W-1:0] cause;
  logic [DATA_W-1:0] epc;
  logic              exc_taken;
  logic              eret_done;
  logic [CODE_W-1:0] exc_code;
  logic              flush_if;
  logic              flush_id;
  logic              flush_exe;
  logic              pc_redirect;
  logic [DATA_W-1:0] pc_target;
  logic              busy;

  modport master (
    output stall, id_syscall, id_unknown, exe_overflow, id_eret, int_req,
           status, cause, epc,
    input  exc_taken, eret_done, exc_code, flush_if, flush_id, flush_exe,
           pc_redirect, pc_target, busy
  );

  modport slave (
    input  stall, id_syscall, id_unknown, exe_overflow, id_eret, int_req,
           status, cause, epc,
    output exc_taken, eret_done, exc_code, flush_if, flush_id, flush_exe,
           pc_redirect, pc_target, busy
  );

endinterface

// File: rtl/exc_prio.sv
// Combinational event priority select and exception-code encode.
module exc_prio
  import exc_pkg::*;
(
  input  logic exe_overflow,
  input  logic id_unknown,
  input  logic id_syscall,
  input  logic id_eret,
  input  logic int_req,
  input  logic st_ie,
  input  logic st_exl,
  input  logic st_erl,
  output evt_t evt_c
);

  logic int_ok_c;

  // Interrupts only when enabled and not already in exception/error level
  assign int_ok_c = int_req && st_ie && !st_exl && !st_erl;

  always_comb begin
    evt_c = '0;
    if (exe_overflow) begin
      evt_c.valid = 1'b1;
      evt_c.code  = EXC_OV;
    end else if (id_unknown) begin
      evt_c.valid = 1'b1;
      evt_c.code  = EXC_RI;
    end else if (id_syscall) begin
      evt_c.valid = 1'b1;
      evt_c.code  = EXC_SYS;
    end else if (id_eret) begin
      evt_c.valid   = 1'b1;
      evt_c.is_eret = 1'b1;
    end else if (int_ok_c) begin
      evt_c.valid  = 1'b1;
      evt_c.is_int = 1'b1;
      evt_c.code   = EXC_INT;
    end
  end

endmodule

// File: rtl/exc_seq.sv
// Exception/ERET sequencer: IDLE -> FLUSH -> REDIRECT with registered outputs.
// Optional VECTORED_INT_EN: interrupts use offset 0x200 when CAUSE.IV is set.
module exc_seq
  import exc_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  exc_seq_if.slave bus
);

  state_t            state_q, state_d;
  logic              flush_q, flush_d;
  logic              exc_taken_q, exc_taken_d;
  logic              eret_done_q, eret_done_d;
  logic              pc_redirect_q, pc_redirect_d;
  logic              busy_q, busy_d;
  logic [CODE_W-1:0] exc_code_q, exc_code_d;
  logic [DATA_W-1:0] pc_target_q, pc_target_d;

  evt_t              evt_c;
  logic [DATA_W-1:0] exc_base_c;
  logic [DATA_W-1:0] exc_off_c;
  logic              unused_c;

  exc_prio u_prio (
    .exe_overflow (bus.exe_overflow),
    .id_unknown   (bus.id_unknown),
    .id_syscall   (bus.id_syscall),
    .id_eret      (bus.id_eret),
    .int_req      (bus.int_req),
    .st_ie        (bus.status[ST_IE]),
    .st_exl       (bus.status[ST_EXL]),
    .st_erl       (bus.status[ST_ERL]),
    .evt_c        (evt_c)
  );

  assign exc_base_c = bus.status[ST_BEV] ? BASE_BEV : BASE_NORMAL;
`ifdef VECTORED_INT_EN
  assign exc_off_c  = (evt_c.is_int && bus.cause[CA_IV]) ? OFF_VEC : OFF_GEN;
`else
  assign exc_off_c  = OFF_GEN;
`endif
  assign unused_c   = ^{bus.cause, bus.status};

  // Next-state and next-output logic
  always_comb begin
    state_d       = state_q;
    flush_d       = 1'b0;
    exc_taken_d   = 1'b0;
    eret_done_d   = 1'b0;
    pc_redirect_d = 1'b0;
    exc_code_d    = exc_code_q;
    pc_target_d   = pc_target_q;
    unique case (state_q)
      ST_IDLE: begin
        if (!bus.stall && evt_c.valid) begin
          state_d     = ST_FLUSH;
          flush_d     = 1'b1;
          exc_taken_d = !evt_c.is_eret;
          eret_done_d = evt_c.is_eret;
          if (!evt_c.is_eret) exc_code_d = evt_c.code;
          pc_target_d = evt_c.is_eret ? bus.epc : DATA_W'(exc_base_c + exc_off_c);
        end
      end
      ST_FLUSH: begin
        state_d       = ST_REDIRECT;
        pc_redirect_d = 1'b1;
      end
      ST_REDIRECT: begin
        if (bus.stall) pc_redirect_d = 1'b1;
        else           state_d       = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      flush_q       <= 1'b0;
      exc_taken_q   <= 1'b0;
      eret_done_q   <= 1'b0;
      pc_redirect_q <= 1'b0;
      busy_q        <= 1'b0;
      exc_code_q    <= '0;
      pc_target_q   <= '0;
    end else begin
      state_q       <= state_d;
      flush_q       <= flush_d;
      exc_taken_q   <= exc_taken_d;
      eret_done_q   <= eret_done_d;
      pc_redirect_q <= pc_redirect_d;
      busy_q        <= busy_d;
      exc_code_q    <= exc_code_d;
      pc_target_q   <= pc_target_d;
    end
  end

  assign bus.flush_if    = flush_q;
  assign bus.flush_id    = flush_q;
  assign bus.flush_exe   = flush_q;
  assign bus.exc_taken   = exc_taken_q;
  assign bus.eret_done   = eret_done_q;
  assign bus.pc_redirect = pc_redirect_q;
  assign bus.busy        = busy_q;
  assign bus.exc_code    = exc_code_q;
  assign bus.pc_target   = pc_target_q;

endmodule

// File: tb/tb_exc_seq.sv
// Bench for exc_seq: directed scenarios plus random stimulus against a
// sequence-timeline reference model (honours VECTORED_INT_EN if defined).
module tb_exc_seq;
  import exc_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  exc_seq_if ifc ();
  exc_seq dut (.clk(clk), .rst(rst), .bus(ifc));

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Reference model: a serviced event is remembered by the edge it was sampled on
  int          cyc       = 0;
  int          seq_start = -1;
  bit          m_eret    = 1'b0;
  logic [4:0]  m_code    = '0;
  logic [31:0] m_tgt     = '0;

  task automatic model_edge();
    bit          hit;
    bit          is_int;
    bit          is_eret;
    logic [4:0]  code;
    logic [31:0] tgt;
    int          off;
    if (rst) begin
      seq_start = -1;
      m_code    = '0;
      m_tgt     = '0;
      m_eret    = 1'b0;
    end else if (seq_start < 0) begin
      hit = 1'b1; is_int = 1'b0; is_eret = 1'b0; code = 5'd0;
      if (ifc.exe_overflow)    code = 5'd12;
      else if (ifc.id_unknown) code = 5'd10;
      else if (ifc.id_syscall) code = 5'd8;
      else if (ifc.id_eret)    is_eret = 1'b1;
      else if (ifc.int_req && ifc.status[0] && !ifc.status[1] && !ifc.status[2]) is_int = 1'b1;
      else hit = 1'b0;
      if (hit && !ifc.stall) begin
        seq_start = cyc;
        m_eret    = is_eret;
        off       = 'h180;
`ifdef VECTORED_INT_EN
        if (is_int && ifc.cause[23]) off = 'h200;
`endif
        tgt = (ifc.status[22] ? 32'hBFC0_0200 : 32'h8000_0000) + 32'(off);
        if (is_eret) m_tgt = ifc.epc;
        else begin
          m_tgt  = tgt;
          m_code = code;
        end
      end
    end else if (cyc >= seq_start + 2 && !ifc.stall) begin
      seq_start = -1;
    end
  endtask

  task automatic check_all();
    bit act, fl, red;
    act = (seq_start >= 0);
    fl  = act && (cyc == seq_start);
    red = act && (cyc > seq_start);
    check("busy",        32'(ifc.busy),        32'(act));
    check("flush_if",    32'(ifc.flush_if),    32'(fl));
    check("flush_id",    32'(ifc.flush_id),    32'(fl));
    check("flush_exe",   32'(ifc.flush_exe),   32'(fl));
    check("exc_taken",   32'(ifc.exc_taken),   32'(fl && !m_eret));
    check("eret_done",   32'(ifc.eret_done),   32'(fl && m_eret));
    check("pc_redirect", 32'(ifc.pc_redirect), 32'(red));
    check("exc_code",    32'(ifc.exc_code),    32'(m_code));
    check("pc_target",   ifc.pc_target,        m_tgt);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
    cyc++;
  endtask

  task automatic clr_evt();
    ifc.id_syscall = 1'b0; ifc.id_unknown = 1'b0; ifc.exe_overflow = 1'b0;
    ifc.id_eret    = 1'b0; ifc.int_req    = 1'b0;
  endtask

  int red_cnt;
  logic [31:0] r;

  initial begin
    rst = 1'b1;
    ifc.stall = 1'b0;
    clr_evt();
    ifc.status = '0; ifc.cause = '0; ifc.epc = '0;
    tick(); tick();
    rst = 1'b0;
    check("reset_busy", 32'(ifc.busy), 32'd0);
    tick();

    // syscall with STATUS=0
    ifc.id_syscall = 1'b1;
    tick();
    check("sys_taken", 32'(ifc.exc_taken), 32'd1);
    check("sys_code",  32'(ifc.exc_code),  32'h08);
    clr_evt();
    tick();
    check("sys_redir",  32'(ifc.pc_redirect), 32'd1);
    check("sys_target", ifc.pc_target,        32'h8000_0180);
    tick();

    // overflow beats syscall, single taken pulse
    ifc.exe_overflow = 1'b1; ifc.id_syscall = 1'b1;
    tick();
    check("ov_code", 32'(ifc.exc_code), 32'h0C);
    tick();
    check("ov_single_pulse", 32'(ifc.exc_taken), 32'd0);
    clr_evt();
    tick(); tick();

    // eret to EPC
    ifc.id_eret = 1'b1; ifc.epc = 32'h0040_0020;
    tick();
    check("eret_done", 32'(ifc.eret_done), 32'd1);
    clr_evt();
    tick();
    check("eret_target", ifc.pc_target, 32'h0040_0020);
    check("eret_code_kept", 32'(ifc.exc_code), 32'h0C);
    tick();

    // interrupt with BEV and IV
    ifc.int_req = 1'b1; ifc.status = 32'h0040_0001; ifc.cause = 32'h0080_0000;
    tick();
    clr_evt();
    tick();
`ifdef VECTORED_INT_EN
    check("int_target", ifc.pc_target, 32'hBFC0_0400);
`else
    check("int_target", ifc.pc_target, 32'hBFC0_0380);
`endif
    tick();

    // masked by EXL
    ifc.int_req = 1'b1; ifc.status = 32'h0040_0003;
    tick();
    check("int_exl_idle", 32'(ifc.busy), 32'd0);
    clr_evt();
    ifc.status = '0;
    tick();

    // stall held in REDIRECT for 3 cycles
    red_cnt = 0;
    ifc.id_syscall = 1'b1;
    tick();
    clr_evt();
    tick(); red_cnt += int'(ifc.pc_redirect);
    ifc.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); red_cnt += int'(ifc.pc_redirect);
      check("stall_target", ifc.pc_target, 32'h8000_0180);
    end
    ifc.stall = 1'b0;
    tick(); red_cnt += int'(ifc.pc_redirect);
    check("stall_redir_cycles", 32'(red_cnt), 32'd4);

    // stall in IDLE defers the event
    ifc.stall = 1'b1; ifc.id_unknown = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_idle_busy", 32'(ifc.busy), 32'd0);
    end
    ifc.stall = 1'b0;
    tick();
    check("deferred_taken", 32'(ifc.exc_taken), 32'd1);
    check("deferred_code",  32'(ifc.exc_code),  32'h0A);
    clr_evt();
    tick(); tick();

    // reset during FLUSH
    ifc.id_syscall = 1'b1;
    tick();
    rst = 1'b1; clr_evt();
    tick();
    check("rst_flush_busy",  32'(ifc.busy),        32'd0);
    check("rst_flush_redir", 32'(ifc.pc_redirect), 32'd0);
    check("rst_flush_tgt",   ifc.pc_target,        32'd0);
    rst = 1'b0;
    tick();

    // random stimulus
    for (int n = 0; n < 3000; n++) begin
      r = $urandom;
      rst              = ($urandom_range(0, 63) == 0);
      ifc.stall        = ($urandom_range(0, 3) == 0);
      ifc.exe_overflow = ($urandom_range(0, 11) == 0);
      ifc.id_unknown   = ($urandom_range(0, 11) == 0);
      ifc.id_syscall   = ($urandom_range(0, 9) == 0);
      ifc.id_eret      = ($urandom_range(0, 9) == 0);
      ifc.int_req      = ($urandom_range(0, 3) == 0);
      ifc.status       = $urandom;
      if (r[0]) ifc.status[2:0] = 3'b001;
      ifc.cause        = $urandom;
      ifc.epc          = $urandom;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/exc_seq.md
EXC_SEQ -- requirements
Module: exc_seq

Interface
REQ-001 SHALL have port clk  in  1  sole clock, rising edge.
REQ-002 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have port stall  in  1  pipeline stall; new events deferred, REDIRECT held.
REQ-004 SHALL have ports id_syscall, id_unknown, exe_overflow, id_eret  in  1 each  exception/eret requests.
REQ-005 SHALL have port int_req  in  1  masked interrupt request from CP0.
REQ-006 SHALL have ports status, cause, epc  in  32 each  current CP0 STATUS/CAUSE/EPC.
REQ-007 SHALL have port exc_taken  out  1  one-cycle pulse; CP0 commits EPC/CAUSE/STATUS.
REQ-008 SHALL have port eret_done  out  1  one-cycle pulse; CP0 restores STATUS.
REQ-009 SHALL have port exc_code  out  5  code of taken exception.
REQ-010 SHALL have ports flush_if, flush_id, flush_exe  out  1 each  stage flushes.
REQ-011 SHALL have ports pc_redirect  out  1 and pc_target  out  32  PC override.
REQ-012 SHALL have port busy  out  1  high while state != IDLE.

Function
REQ-013 SHALL implement states IDLE, FLUSH, REDIRECT; all outputs registered.
REQ-014 SHALL sample events only in IDLE with stall=0; with stall=1 events are not consumed and are re-sampled once stall falls.
REQ-015 SHALL prioritise exe_overflow > id_unknown > id_syscall > id_eret > int_req; one event serviced per sequence.
REQ-016 SHALL encode exc_code: int 0x00, syscall 0x08, unknown 0x0A, overflow 0x0C; eret leaves exc_code unchanged.
REQ-017 SHALL ignore int_req when status[1] (EXL) or status[2] (ERL) is 1, or status[0] (IE) is 0.
REQ-018 SHALL, on a sampled event at edge N, enter FLUSH at N+1 with flush_if/id/exe=1 for exactly that cycle; exc_taken=1 same cycle for exceptions, eret_done=1 same cycle for eret.
REQ-019 SHALL move FLUSH->REDIRECT unconditionally; REDIRECT drives pc_redirect=1 with latched pc_target.
REQ-020 SHALL hold REDIRECT (pc_redirect=1, target stable) while stall=1; exit to IDLE on first cycle with stall=0.
REQ-021 SHALL compute exception target: base = status[22] ? 0xBFC00200 : 0x80000000; offset 0x180; target = base+offset, latched at sampling edge.
REQ-022 SHALL use target = epc (latched at sampling edge) for eret.
REQ-023 SHALL ignore all event inputs in FLUSH and REDIRECT (flushed sources re-raise if still valid).
REQ-024 SHALL give total latency event->pc_redirect of 2 cycles when stall=0.

Reset
REQ-025 SHALL, on rst=1 at any edge incl. mid-sequence, enter IDLE; all outputs 0, exc_code 0, pc_target 0; pending latched event discarded.

Configuration
REQ-026 SHALL, with VECTORED_INT_EN defined, use offset 0x200 for interrupts when cause[23] (IV)=1; without it, offset is always 0x180 and cause[23] is ignored.

Structure
REQ-027 SHALL place exception codes, state encoding, base/offset constants in package exc_pkg.
REQ-028 SHALL isolate priority selection and code encode in combinational sub-module exc_prio.

Verification
REQ-029 SHALL cover: id_syscall=1, status=0 -> next cycle exc_taken=1, exc_code=0x08, flushes=1; following cycle pc_redirect=1, pc_target=0x80000180.
REQ-030 SHALL cover: exe_overflow and id_syscall together -> exc_code=0x0C, single exc_taken pulse.
REQ-031 SHALL cover: id_eret=1, epc=0x00400020 -> eret_done pulse, then pc_target=0x00400020, exc_taken=0.
REQ-032 SHALL cover: int_req=1, status=0x00400001, cause[23]=1 -> target 0xBFC00400 with VECTORED_INT_EN, 0xBFC00380 without; int_req with status[1]=1 -> no action.
REQ-033 SHALL cover: stall=1 in REDIRECT for 3 cycles -> pc_redirect held 4 cycles, target stable; stall=1 in IDLE with event -> no action until stall=0.
REQ-034 SHALL cover: rst=1 during FLUSH -> next cycle IDLE, busy=0, all outputs 0, no pc_redirect.
